alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter data_width, default 16, operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous clear of buffered operands, active-high.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 in_A  input  data_width  first operand.
REQ-008 in_B  input  data_width  second operand.
REQ-009 in_FuncCode  input  4  ALU function code (FUNC_ADD / FUNC_SUB encoding).
REQ-010 out_valid  output  1  A/B/FuncCode hold a valid operation for the add/sub ALU.
REQ-011 out_ready  input  1  downstream ALU consumes the operation this cycle.
REQ-012 A, B  output  data_width each  registered operands driven to the ALU.
REQ-013 FuncCode  output  4  registered function code driven to the ALU.
REQ-014 count  output  2  current occupancy, 0..2.

Function
REQ-015 Stage SHALL be a 2-entry in-order skid buffer: main register (drives outputs) plus skid register.
REQ-016 accept = in_valid && in_ready; release = out_valid && out_ready.
REQ-017 States SHALL be EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-018 EMPTY: accept -> ONE, main <= input.
REQ-019 ONE: accept && release -> ONE, main <= input; accept only -> FULL, skid <= input; release only -> EMPTY; neither -> hold.
REQ-020 FULL: release -> ONE, main <= skid; otherwise hold.
REQ-021 in_ready SHALL be 1 iff state != FULL and reset is low; it SHALL depend only on registered state (no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 iff state != EMPTY; A/B/FuncCode SHALL come straight from main register.
REQ-023 Latency from accept to out_valid SHALL be exactly 1 cycle when the stage is empty.
REQ-024 While out_valid && !out_ready, A/B/FuncCode SHALL remain stable.
REQ-025 Operations SHALL leave in acceptance order; none dropped or duplicated.
REQ-026 flush SHALL force EMPTY next cycle and take priority over a same-cycle accept or release; data registers may hold stale values.
REQ-027 When out_valid is 0, A/B/FuncCode SHALL hold their last value.
REQ-028 FuncCode SHALL be passed unmodified; no decoding or width change of operands.

Reset
REQ-029 reset high SHALL on the next edge set state EMPTY, count 0, out_valid 0, A/B/FuncCode/skid all zero.
REQ-030 reset asserted mid-transfer SHALL discard all buffered operations; in_ready becomes 1 the first cycle after reset deasserts.

Configuration
REQ-031 Macro ALU_OPERAND_FWD_EN SHALL add inputs fwd_data (data_width), fwd_sel_A (1), fwd_sel_B (1).
REQ-032 With ALU_OPERAND_FWD_EN defined, on accept fwd_sel_A/fwd_sel_B SHALL substitute fwd_data for in_A/in_B respectively, sampled in the accept cycle.
REQ-033 Without ALU_OPERAND_FWD_EN, these ports SHALL not exist and in_A/in_B are always captured.

Structure
REQ-034 FUNC_ADD/FUNC_SUB codes and EMPTY/ONE/FULL state encodings SHALL live in the shared ALU package header.
REQ-035 One sub-module alu_operand_reg (enable-loaded register of A, B, FuncCode) SHALL be instantiated twice: main and skid.

Verification
REQ-036 Reset then single accept in_A=0x0005, in_B=0x0003, in_FuncCode=FUNC_ADD, out_ready=1 -> next cycle out_valid=1, A=0x0005, B=0x0003; count returns to 0 after release.
REQ-037 out_ready=0, accept 0x1111 then 0x2222 -> count=2, in_ready=0, A=0x1111 stable; raise out_ready -> 0x1111 then 0x2222 in order, in_ready=1 one cycle after first release.
REQ-038 Streaming 8 ops (A=0..7) with in_valid=out_ready=1 -> one output per cycle, count stays 1, order 0..7.
REQ-039 count=2 with flush=1 and in_valid=1 same cycle -> next cycle count=0, out_valid=0, new op not captured.
REQ-040 Reset asserted while count=2 -> next cycle out_valid=0, A=B=0, FuncCode=0.
REQ-041 ALU_OPERAND_FWD_EN: in_A=0x0001, fwd_data=0xFFFF, fwd_sel_A=1, fwd_sel_B=0, in_B=0x0002 -> A=0xFFFF, B=0x0002.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_pkg
//   Shared ALU definitions: function codes understood by the add/sub ALU,
//   the state encoding of the operand skid buffer, and a helper that maps
//   a buffer state to its occupancy count.
//
//   Optional feature macro used by the stage: ALU_OPERAND_FWD_EN
//   (operand forwarding inputs). Nothing in this package depends on it.
// -----------------------------------------------------------------------------
package alu_operand_stage_pkg;

  // Width of the ALU function code field.
  localparam int FUNC_W = 4;

  // Function codes decoded by the downstream add/sub ALU.
  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'h0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'h1;

  // Occupancy states of the 2-entry operand buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Number of buffered operations held in a given state.
  function automatic logic [1:0] state_count(input state_e st);
    logic [1:0] cnt;
    case (st)
      ST_EMPTY: cnt = 2'd0;
      ST_ONE:   cnt = 2'd1;
      ST_FULL:  cnt = 2'd2;
      default:  cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage : alu_operand_stage_pkg

// File: rtl/alu_operand_reg.sv
// -----------------------------------------------------------------------------
// alu_operand_reg
//   Enable-loaded register holding one ALU operation (A, B, FuncCode).
//   Used twice by alu_operand_stage: once as the main (output) register and
//   once as the skid register.
//
//   Ports:
//     clk_i      clock, rising edge
//     reset_i    synchronous active-high reset, clears all fields to zero
//     load_i     capture a_i/b_i/func_i on the next rising edge
//     a_i, b_i   operand inputs (data_width bits)
//     func_i     function code input (FUNC_W bits)
//     a_o, b_o   registered operands
//     func_o     registered function code
// -----------------------------------------------------------------------------
module alu_operand_reg
  import alu_operand_stage_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [data_width-1:0] a_i,
  input  logic [data_width-1:0] b_i,
  input  logic [FUNC_W-1:0]     func_i,
  output logic [data_width-1:0] a_o,
  output logic [data_width-1:0] b_o,
  output logic [FUNC_W-1:0]     func_o
);

  logic [data_width-1:0] a_q;
  logic [data_width-1:0] b_q;
  logic [FUNC_W-1:0]     func_q;

  // Operation storage: zero on reset, load on enable, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q    <= {data_width{1'b0}};
      b_q    <= {data_width{1'b0}};
      func_q <= {FUNC_W{1'b0}};
    end else if (load_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      func_q <= func_i;
    end else begin
      a_q    <= a_q;
      b_q    <= b_q;
      func_q <= func_q;
    end
  end

  assign a_o    = a_q;
  assign b_o    = b_q;
  assign func_o = func_q;

endmodule : alu_operand_reg

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Two-entry in-order skid buffer sitting in front of the add/sub ALU.
//   The main register drives A/B/FuncCode directly; the skid register
//   absorbs one extra operation so that in_ready can be a pure function of
//   registered state (no combinational path from out_ready to in_ready).
//
//   Optional feature: define ALU_OPERAND_FWD_EN to add the forwarding inputs
//   fwd_data / fwd_sel_A / fwd_sel_B. When a select is high in the accept
//   cycle, fwd_data is captured in place of in_A / in_B.
//
//   Ports:
//     clk          clock, rising edge
//     reset        synchronous active-high reset (empties the buffer and
//                  zeroes both operation registers)
//     flush        synchronous clear of buffered operations (data registers
//                  keep stale contents)
//     in_valid     upstream offers an operation
//     in_ready     stage can accept an operation this cycle
//     in_A, in_B   operands offered upstream
//     in_FuncCode  function code offered upstream (passed unmodified)
//     out_valid    A/B/FuncCode hold a valid operation
//     out_ready    downstream ALU consumes the operation this cycle
//     A, B         operands driven to the ALU (from the main register)
//     FuncCode     function code driven to the ALU (from the main register)
//     count        buffer occupancy, 0..2
//     fwd_data     (ALU_OPERAND_FWD_EN only) forwarded operand value
//     fwd_sel_A    (ALU_OPERAND_FWD_EN only) capture fwd_data as A
//     fwd_sel_B    (ALU_OPERAND_FWD_EN only) capture fwd_data as B
// -----------------------------------------------------------------------------
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_A,
  input  logic [data_width-1:0] in_B,
  input  logic [FUNC_W-1:0]     in_FuncCode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] A,
  output logic [data_width-1:0] B,
  output logic [FUNC_W-1:0]     FuncCode,
  output logic [1:0]            count
`ifdef ALU_OPERAND_FWD_EN
  ,
  input  logic [data_width-1:0] fwd_data,
  input  logic                  fwd_sel_A,
  input  logic                  fwd_sel_B
`endif
);

  // Buffer state and registered handshake outputs.
  state_e     state_q;
  state_e     state_d;
  logic       out_valid_q;
  logic       in_ready_q;
  logic [1:0] count_q;

  // Handshake events.
  logic accept_s;
  logic release_s;

  // Register load controls decoded from state and handshakes.
  logic main_load_s;
  logic main_from_skid_s;
  logic skid_load_s;

  // Operation as captured from upstream (after optional forwarding).
  logic [data_width-1:0] cap_a_s;
  logic [data_width-1:0] cap_b_s;

  // Data presented to the main register.
  logic [data_width-1:0] main_a_s;
  logic [data_width-1:0] main_b_s;
  logic [FUNC_W-1:0]     main_func_s;

  // Register contents.
  logic [data_width-1:0] main_a_q;
  logic [data_width-1:0] main_b_q;
  logic [FUNC_W-1:0]     main_func_q;
  logic [data_width-1:0] skid_a_q;
  logic [data_width-1:0] skid_b_q;
  logic [FUNC_W-1:0]     skid_func_q;

  // in_ready is registered; the reset term only blanks it while reset is
  // held so nothing is offered to an upstream that would be thrown away.
  assign in_ready  = in_ready_q & ~reset;
  assign out_valid = out_valid_q;
  assign count     = count_q;

  assign accept_s  = in_valid & in_ready;
  assign release_s = out_valid_q & out_ready;

`ifdef ALU_OPERAND_FWD_EN
  // Forwarding substitutes fwd_data per operand, sampled in the accept cycle.
  always_comb begin
    if (fwd_sel_A) begin
      cap_a_s = fwd_data;
    end else begin
      cap_a_s = in_A;
    end
    if (fwd_sel_B) begin
      cap_b_s = fwd_data;
    end else begin
      cap_b_s = in_B;
    end
  end
`else
  // Without forwarding the upstream operands are captured as-is.
  always_comb begin
    cap_a_s = in_A;
    cap_b_s = in_B;
  end
`endif

  // Next-state and register load decode; flush overrides any handshake.
  always_comb begin
    state_d          = state_q;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d     = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && release_s) begin
            // Pass-through: the new operation replaces the departing one.
            state_d     = ST_ONE;
            main_load_s = 1'b1;
          end else if (accept_s) begin
            // Main is stalled, so the newcomer waits in the skid register.
            state_d     = ST_FULL;
            skid_load_s = 1'b1;
          end else if (release_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a release can move the state.
          if (release_s) begin
            state_d          = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Main register source: the older skid entry when draining FULL,
  // otherwise the operation arriving from upstream.
  always_comb begin
    if (main_from_skid_s) begin
      main_a_s    = skid_a_q;
      main_b_s    = skid_b_q;
      main_func_s = skid_func_q;
    end else begin
      main_a_s    = cap_a_s;
      main_b_s    = cap_b_s;
      main_func_s = in_FuncCode;
    end
  end

  // Occupancy FSM with registered out_valid, in_ready and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_FULL);
      count_q     <= state_count(state_d);
    end
  end

  alu_operand_reg #(
    .data_width (data_width)
  ) u_main_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (main_load_s),
    .a_i     (main_a_s),
    .b_i     (main_b_s),
    .func_i  (main_func_s),
    .a_o     (main_a_q),
    .b_o     (main_b_q),
    .func_o  (main_func_q)
  );

  alu_operand_reg #(
    .data_width (data_width)
  ) u_skid_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (skid_load_s),
    .a_i     (cap_a_s),
    .b_i     (cap_b_s),
    .func_i  (in_FuncCode),
    .a_o     (skid_a_q),
    .b_o     (skid_b_q),
    .func_o  (skid_func_q)
  );

  assign A        = main_a_q;
  assign B        = main_b_q;
  assign FuncCode = main_func_q;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//   Scoreboard bench for alu_operand_stage. The reference model is an
//   in-order queue of at most two operations: an accepted operation is
//   pushed, a released one is popped, flush/reset empty it. The monitor
//   compares count/out_valid/in_ready and the presented operation with the
//   queue every cycle and pops on each release.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  localparam int DW = 16;
`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    f;
  } op_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_A;
  logic [DW-1:0] in_B;
  logic [3:0]    in_FuncCode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [3:0]    FuncCode;
  logic [1:0]    count;
`ifdef ALU_OPERAND_FWD_EN
  logic [DW-1:0] fwd_data;
  logic          fwd_sel_A;
  logic          fwd_sel_B;
`endif

  op_t  exp_q[$];
  op_t  last_front;
  logic zero_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rel    = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.data_width(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_A        (in_A),
    .in_B        (in_B),
    .in_FuncCode (in_FuncCode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .A           (A),
    .B           (B),
    .FuncCode    (FuncCode),
    .count       (count)
`ifdef ALU_OPERAND_FWD_EN
    ,
    .fwd_data    (fwd_data),
    .fwd_sel_A   (fwd_sel_A),
    .fwd_sel_B   (fwd_sel_B)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, update the model after the edge.
  task automatic step(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [3:0] f, input logic ordy, input logic fl, input logic rs,
                      input logic fsa, input logic fsb, input logic [DW-1:0] fd);
    bit  acc;
    op_t cap;
    @(negedge clk);
    in_valid    = v;
    in_A        = a;
    in_B        = b;
    in_FuncCode = f;
    out_ready   = ordy;
    flush       = fl;
    reset       = rs;
`ifdef ALU_OPERAND_FWD_EN
    fwd_data    = fd;
    fwd_sel_A   = fsa;
    fwd_sel_B   = fsb;
`endif
    acc   = v && (exp_q.size() < 2) && !rs && !fl;
    cap.a = (FWD && fsa) ? fd : a;
    cap.b = (FWD && fsb) ? fd : b;
    cap.f = f;
    @(posedge clk);
    #1;
    if (rs) begin
      exp_q.delete();
      zero_exp = 1'b1;
    end else if (fl) begin
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back(cap);
      zero_exp = 1'b0;
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, ordy, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f,
                      input logic ordy);
    step(1'b1, a, b, f, ordy, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Monitor: compare DUT view with the model queue, pop on release.
  initial begin
    int  sz;
    op_t front;
    forever begin
      @(negedge clk);
      #2;
      sz = exp_q.size();
      check("count", 32'(count), 32'(sz));
      check("out_valid", 32'(out_valid), 32'(sz > 0));
      check("in_ready", 32'(in_ready), 32'((sz < 2) && !reset));
      if (sz > 0) begin
        front = exp_q[0];
        check("A", 32'(A), 32'(front.a));
        check("B", 32'(B), 32'(front.b));
        check("FuncCode", 32'(FuncCode), 32'(front.f));
        last_front = front;
        if (out_ready && !reset && !flush) begin
          void'(exp_q.pop_front());
          n_rel++;
        end
      end else if (zero_exp) begin
        check("A_zero", 32'(A), 32'h0);
        check("B_zero", 32'(B), 32'h0);
        check("FuncCode_zero", 32'(FuncCode), 32'h0);
      end else begin
        check("A_hold", 32'(A), 32'(last_front.a));
        check("B_hold", 32'(B), 32'(last_front.b));
        check("FuncCode_hold", 32'(FuncCode), 32'(last_front.f));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_A        = 16'h0000;
    in_B        = 16'h0000;
    in_FuncCode = 4'h0;
    out_ready   = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
    fwd_data    = 16'h0000;
    fwd_sel_A   = 1'b0;
    fwd_sel_B   = 1'b0;
`endif
    zero_exp    = 1'b1;
    last_front  = '0;

    // Reset.
    repeat (3) step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(1'b1);

    // Single operation through an empty stage.
    send(16'h0005, 16'h0003, FUNC_ADD, 1'b1);
    repeat (3) idle(1'b1);

    // Fill to two under backpressure, hold, then drain in order.
    send(16'h1111, 16'h0101, FUNC_ADD, 1'b0);
    send(16'h2222, 16'h0202, FUNC_SUB, 1'b0);
    repeat (3) idle(1'b0);
    repeat (3) idle(1'b1);

    // Full-rate streaming.
    for (int i = 0; i < 8; i++) send(16'(i), 16'(i + 100), FUNC_SUB, 1'b1);
    repeat (2) idle(1'b1);

    // Flush while full with a same-cycle offer.
    send(16'h3333, 16'h0303, FUNC_ADD, 1'b0);
    send(16'h4444, 16'h0404, FUNC_SUB, 1'b0);
    step(1'b1, 16'hBEEF, 16'hCAFE, FUNC_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) idle(1'b0);
    idle(1'b1);

    // Reset while full.
    send(16'h5555, 16'h0505, FUNC_ADD, 1'b0);
    send(16'h6666, 16'h0606, FUNC_SUB, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (2) idle(1'b1);

`ifdef ALU_OPERAND_FWD_EN
    // Forwarding substitutes A only.
    step(1'b1, 16'h0001, 16'h0002, FUNC_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    repeat (2) idle(1'b1);
`endif

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 4'($urandom),
           ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 97) == 0,
           1'($urandom), 1'($urandom), 16'($urandom));
    end
    repeat (4) idle(1'b1);

    check("releases_seen", 32'(n_rel > 20), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_operand_stage
